// File: rtl/nv_nvdla_cmac_core_done_ctrl.sv
// CMAC layer-completion tracker: counts strips into and out of the MAC array
// and raises a one-cycle done pulse when the last result of the layer leaves.
module nv_nvdla_cmac_core_done_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             reg2dp_op_en,
    input  logic             cfg_reg_en,
    input  logic [CNT_W-1:0] reg2dp_strip_num,
    input  logic             in_dat_pvld,
    input  logic             in_dat_layer_end,
    input  logic             out_dat_pvld,
    output logic             dp2reg_done,
    output logic             core_busy,
    output logic [2:0]       err_status
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             in_at;
    logic             out_at;

    // Counters stop at target instead of wrapping, so the all-ones target is legal.
    assign in_at  = (in_cnt == target);
    assign out_at = (out_cnt == target);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state       <= IDLE;
            target      <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            dp2reg_done <= 1'b0;
            core_busy   <= 1'b0;
            err_status  <= 3'b000;
        end else begin
            dp2reg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_reg_en && reg2dp_op_en) begin
                        state      <= RUN;
                        target     <= reg2dp_strip_num;
                        in_cnt     <= '0;
                        out_cnt    <= '0;
                        err_status <= 3'b000;
                        core_busy  <= 1'b1;
                    end else if (out_dat_pvld) begin
                        err_status[2] <= 1'b1;
                    end
                end
                RUN: begin
                    if (!reg2dp_op_en) begin
                        state     <= IDLE;
                        core_busy <= 1'b0;
                    end else begin
                        if (in_dat_pvld) begin
                            if (in_dat_layer_end != in_at)
                                err_status[1] <= 1'b1;
                            if (!in_at)
                                in_cnt <= in_cnt + 1'b1;
                        end
                        if (out_dat_pvld && !out_at)
                            out_cnt <= out_cnt + 1'b1;
                        if (in_dat_pvld && in_at) begin
                            if (out_dat_pvld && out_at) begin
                                state       <= DONE;
                                dp2reg_done <= 1'b1;
                                core_busy   <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!reg2dp_op_en) begin
                        state     <= IDLE;
                        core_busy <= 1'b0;
                    end else begin
                        if (in_dat_pvld)
                            err_status[0] <= 1'b1;
                        if (out_dat_pvld) begin
                            if (out_at) begin
                                state       <= DONE;
                                dp2reg_done <= 1'b1;
                                core_busy   <= 1'b0;
                            end else begin
                                out_cnt <= out_cnt + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (in_dat_pvld)
                        err_status[0] <= 1'b1;
                    if (out_dat_pvld)
                        err_status[2] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
